// File: rtl/spi_cmd_handler.sv
// SPI master command engine: one exec request becomes one chip-select-framed
// 2*PACKAGE_SIZE bit register access (R/W flag, address, data), MSB first.
module spi_cmd_handler #(
   parameter int PACKAGE_SIZE = 8
) (
   input  logic                    clk,
   input  logic                    rstb,
   input  logic [PACKAGE_SIZE-1:0] cmd,
   input  logic [PACKAGE_SIZE-1:0] data_in,
   input  logic [PACKAGE_SIZE-2:0] addr_in,
   input  logic                    exec,
   output logic                    busy,
   output logic [PACKAGE_SIZE-1:0] data_out,
   input  logic                    sdi,
   output logic                    csb,
   output logic                    sdo
);

   localparam int FRAME_LEN = 2 * PACKAGE_SIZE;
   localparam int CNT_W     = $clog2(FRAME_LEN) + 1;

   localparam logic [PACKAGE_SIZE-1:0] CMD_WRITE    = PACKAGE_SIZE'(1);
   localparam logic [PACKAGE_SIZE-1:0] CMD_READ     = PACKAGE_SIZE'(2);
   localparam logic [CNT_W-1:0]        LAST_BIT     = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0]        FIRST_SAMPLE = CNT_W'(PACKAGE_SIZE - 1);
   localparam logic [CNT_W-1:0]        LAST_SAMPLE  = CNT_W'(FRAME_LEN - 2);

   typedef enum logic {IDLE, XFER} state_t;

   state_t                  r_state, w_nextState;
   logic [CNT_W-1:0]        r_cnt, w_cntNext;
   logic [FRAME_LEN-1:0]    r_shift, w_shiftNext;
   logic                    r_isRead, w_isReadNext;
   logic                    r_csb, w_csbNext;
   logic                    r_busy, w_busyNext;
   logic                    r_sdo, w_sdoNext;
   logic [PACKAGE_SIZE-1:0] r_dataOut, w_dataOutNext;
   logic [PACKAGE_SIZE-1:0] w_dataField;
   logic                    w_cmdValid, w_isReadCmd, w_start;

   assign w_cmdValid  = (cmd == CMD_WRITE) || (cmd == CMD_READ);
   assign w_isReadCmd = (cmd == CMD_READ);
   assign w_start     = (r_state == IDLE) && exec && w_cmdValid;
   // Reads clock out zeros during the data phase
   assign w_dataField = w_isReadCmd ? '0 : data_in;

   always_ff @(posedge clk) begin
      if (rstb) r_state <= IDLE;
      else      r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_start) w_nextState = XFER;
         XFER:    if (r_cnt == LAST_BIT) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Bit 0 goes out on the start edge; the shift register holds bits 1..N-1
   always_comb begin
      w_cntNext     = r_cnt;
      w_shiftNext   = r_shift;
      w_isReadNext  = r_isRead;
      w_csbNext     = r_csb;
      w_busyNext    = r_busy;
      w_sdoNext     = r_sdo;
      w_dataOutNext = r_dataOut;
      case (r_state)
         IDLE: begin
            if (w_start) begin
               w_isReadNext = w_isReadCmd;
               w_sdoNext    = w_isReadCmd;
               w_shiftNext  = {addr_in, w_dataField, 1'b0};
               w_cntNext    = '0;
               w_csbNext    = 1'b0;
               w_busyNext   = 1'b1;
            end
         end
         XFER: begin
            if (r_cnt == LAST_BIT) begin
               w_csbNext  = 1'b1;
               w_busyNext = 1'b0;
               w_sdoNext  = 1'b0;
               w_cntNext  = '0;
            end else begin
               w_sdoNext   = r_shift[FRAME_LEN-1];
               w_shiftNext = {r_shift[FRAME_LEN-2:0], 1'b0};
               w_cntNext   = r_cnt + CNT_W'(1);
            end
            if (r_isRead && (r_cnt >= FIRST_SAMPLE) && (r_cnt <= LAST_SAMPLE))
               w_dataOutNext = {r_dataOut[PACKAGE_SIZE-2:0], sdi};
         end
         default: begin
            w_csbNext  = 1'b1;
            w_busyNext = 1'b0;
            w_sdoNext  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rstb) begin
         r_cnt     <= '0;
         r_shift   <= '0;
         r_isRead  <= 1'b0;
         r_csb     <= 1'b1;
         r_busy    <= 1'b0;
         r_sdo     <= 1'b0;
         r_dataOut <= '0;
      end else begin
         r_cnt     <= w_cntNext;
         r_shift   <= w_shiftNext;
         r_isRead  <= w_isReadNext;
         r_csb     <= w_csbNext;
         r_busy    <= w_busyNext;
         r_sdo     <= w_sdoNext;
         r_dataOut <= w_dataOutNext;
      end
   end

   assign csb      = r_csb;
   assign busy     = r_busy;
   assign sdo      = r_sdo;
   assign data_out = r_dataOut;

endmodule

// File: tb/tb_spi_cmd_handler.sv
// Self-checking bench for spi_cmd_handler: a negedge monitor captures each
// csb-framed bit stream and compares it against a queue of expected frames.
module tb_spi_cmd_handler;

   logic       clk;
   logic       rstb;
   logic [7:0] cmd;
   logic [7:0] data_in;
   logic [6:0] addr_in;
   logic       exec;
   logic       busy;
   logic [7:0] data_out;
   logic       sdi;
   logic       csb;
   logic       sdo;

   spi_cmd_handler #(.PACKAGE_SIZE(8)) dut (
      .clk      (clk),
      .rstb     (rstb),
      .cmd      (cmd),
      .data_in  (data_in),
      .addr_in  (addr_in),
      .exec     (exec),
      .busy     (busy),
      .data_out (data_out),
      .sdi      (sdi),
      .csb      (csb),
      .sdo      (sdo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] bits;
      logic [7:0]  dout;
   } expT;

   expT        expQ[$];
   int         gapLog[$];
   int         total = 0;
   int         bad = 0;
   bit         monEn = 0;
   logic [7:0] modelDout = 8'h00;
   logic [15:0] monBits = 16'h0;
   int         monLen = 0;
   int         highRun = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
      end
   endtask

   // Frame monitor: collects sdo while csb is low, scores the frame when csb rises
   always @(negedge clk) begin
      if (!monEn) begin
         monLen  = 0;
         highRun = 0;
      end else begin
         checkOutput("busyVsCsb", {31'b0, busy}, {31'b0, ~csb});
         if (!csb) begin
            if (monLen == 0) gapLog.push_back(highRun);
            monBits = {monBits[14:0], sdo};
            monLen++;
            highRun = 0;
         end else begin
            highRun++;
            if (monLen != 0) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpectedFrame", 32'd1, 32'd0);
               end else begin
                  expT e;
                  e = expQ.pop_front();
                  checkOutput("frameBits", {16'h0, monBits}, {16'h0, e.bits});
                  checkOutput("frameLen", monLen, 32'd16);
                  checkOutput("dataOut", {24'h0, data_out}, {24'h0, e.dout});
               end
               monLen = 0;
            end
         end
      end
   end

   // Drives one request; sdiPat[15-k] is the sdi level sampled at edge P_k
   task automatic applyStimulus(input logic [7:0] c, input logic [6:0] a, input logic [7:0] d,
                                input logic [15:0] sdiPat, input bit midPulse);
      expT e;
      @(negedge clk);
      cmd = c; addr_in = a; data_in = d; exec = 1'b1; sdi = sdiPat[15];
      if (c == 8'h02) begin
         e.bits    = {1'b1, a, 8'h00};
         modelDout = sdiPat[7:0];
      end else begin
         e.bits = {1'b0, a, d};
      end
      e.dout = modelDout;
      expQ.push_back(e);
      @(negedge clk);
      exec = 1'b0;
      for (int k = 1; k < 16; k++) begin
         sdi = sdiPat[15-k];
         if (midPulse && k == 5) begin
            exec = 1'b1; cmd = 8'h02; addr_in = ~a; data_in = ~d;
         end
         if (midPulse && k == 6) exec = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 60 && expQ.size() != 0; i++) @(negedge clk);
      checkOutput("drainPending", expQ.size(), 32'd0);
   endtask

   task automatic idleWatch(input string tag, input int n);
      int violations = 0;
      repeat (n) begin
         @(negedge clk);
         if (csb !== 1'b1 || busy !== 1'b0) violations++;
      end
      checkOutput(tag, violations, 32'd0);
   endtask

   initial begin
      clk = 1'b0; rstb = 1'b1; exec = 1'b0; cmd = 8'h00;
      addr_in = 7'h00; data_in = 8'h00; sdi = 1'b0;

      repeat (3) @(negedge clk);
      checkOutput("resetCsb", {31'b0, csb}, 32'd1);
      checkOutput("resetBusy", {31'b0, busy}, 32'd0);
      checkOutput("resetSdo", {31'b0, sdo}, 32'd0);
      checkOutput("resetDout", {24'h0, data_out}, 32'd0);
      rstb = 1'b0;
      monEn = 1'b1;

      applyStimulus(8'h01, 7'h05, 8'h27, 16'h0000, 1'b0);
      waitDrain();
      applyStimulus(8'h02, 7'h07, 8'h00, 16'hAAAA, 1'b0);
      waitDrain();
      checkOutput("readAA", {24'h0, data_out}, 32'hAA);

      for (int i = 0; i < 4; i++) begin
         logic [7:0]  rc;
         logic [15:0] rp;
         rc = 8'($urandom_range(1, 2));
         rp = 16'($urandom);
         applyStimulus(rc, 7'($urandom), 8'($urandom), rp, 1'b0);
         waitDrain();
      end

      applyStimulus(8'h01, 7'h12, 8'h5A, 16'h0000, 1'b1);
      waitDrain();
      idleWatch("noSecondFrame", 20);

      @(negedge clk);
      cmd = 8'h00; exec = 1'b1;
      idleWatch("invalidCmd00", 20);
      cmd = 8'h03;
      idleWatch("invalidCmd03", 20);
      exec = 1'b0;

      gapLog.delete();
      @(negedge clk);
      cmd = 8'h01; addr_in = 7'h2A; data_in = 8'hC3; exec = 1'b1;
      for (int i = 0; i < 3; i++) begin
         expT e;
         e.bits = {1'b0, 7'h2A, 8'hC3};
         e.dout = modelDout;
         expQ.push_back(e);
      end
      repeat (40) @(negedge clk);
      exec = 1'b0;
      waitDrain();
      checkOutput("b2bCount", gapLog.size(), 32'd3);
      if (gapLog.size() >= 3) begin
         checkOutput("b2bGap1", gapLog[1], 32'd1);
         checkOutput("b2bGap2", gapLog[2], 32'd1);
      end

      applyStimulus(8'h02, 7'h01, 8'h00, 16'h0081, 1'b0);
      waitDrain();
      checkOutput("readBeforeReset", {24'h0, data_out}, 32'h81);

      @(negedge clk);
      monEn = 1'b0;
      cmd = 8'h01; addr_in = 7'h7F; data_in = 8'hFF; exec = 1'b1;
      @(negedge clk);
      exec = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("midFrameCsb", {31'b0, csb}, 32'd0);
      rstb = 1'b1;
      @(negedge clk);
      checkOutput("abortCsb", {31'b0, csb}, 32'd1);
      checkOutput("abortBusy", {31'b0, busy}, 32'd0);
      checkOutput("abortSdo", {31'b0, sdo}, 32'd0);
      checkOutput("abortDout", {24'h0, data_out}, 32'd0);
      repeat (9) @(negedge clk);
      rstb = 1'b0;
      modelDout = 8'h00;
      monEn = 1'b1;
      idleWatch("noResume", 20);
      checkOutput("doutAfterReset", {24'h0, data_out}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
